lfsr_key_source: RTL and testbench

Parametrised LFSR key source for the AES datapath. It generates KEY_W-bit pseudo-random keys from a Fibonacci LFSR that advances STEP bits per clock, and accepts runtime reseeding. After each seed it discards WARMUP cycles of output. Keys are delivered over a valid/ready handshake to the key-expansion stage.

---
 rtl/lfsr_key_pkg.sv | 36 +++
 rtl/lfsr_key_source_core.sv | 37 +++
 rtl/lfsr_key_source.sv | 93 +++++++++
 tb/tb_lfsr_key_source.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_key_pkg.sv
// Shared types, constants and the multi-step LFSR advance used by the key source.
package lfsr_key_pkg;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest LFSR the advance function handles; narrower LFSRs are zero-extended.
  localparam int LFSR_MAX_W = 256;

  // x^128 + x^127 + x^126 + x^121 + 1
  localparam logic [127:0] TAP_MASK_128 = (128'd1 << 127) | (128'd1 << 126) |
                                          (128'd1 << 125) | (128'd1 << 120);

  // Apply `steps` single Fibonacci steps to a `width`-bit LFSR:
  // fb = XOR(lfsr & mask); lfsr = {lfsr[width-2:0], fb}.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_adv(
    input logic [LFSR_MAX_W-1:0] lfsr,
    input logic [LFSR_MAX_W-1:0] mask,
    input int                    steps,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] v;
    logic [LFSR_MAX_W-1:0] wmask;
    logic                  fb;
    wmask = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
    v     = lfsr & wmask;
    for (int i = 0; i < steps; i++) begin
      fb = ^(v & mask & wmask);
      v  = ((v << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & wmask;
    end
    return v;
  endfunction

endpackage

// File: rtl/lfsr_key_source_core.sv
// LFSR register: advances STEP bits every clock, or loads a seed (zero seeds become 1).
module lfsr_core
  import lfsr_key_pkg::*;
#(
  parameter int               KEY_W    = 128,
  parameter int               STEP     = 8,
  parameter logic [KEY_W-1:0] TAP_MASK = KEY_W'(TAP_MASK_128),
  parameter logic [KEY_W-1:0] SEED_DEF = KEY_W'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [KEY_W-1:0] seed,
  output logic [KEY_W-1:0] lfsr
);

  logic [KEY_W-1:0] next_lfsr;

  // Next LFSR value after STEP single steps.
  always_comb begin
    next_lfsr = KEY_W'(lfsr_adv(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAP_MASK), STEP, KEY_W));
  end

  // State register: seed load wins over the free-running advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED_DEF;
    end else if (load) begin
      lfsr <= (seed == '0) ? KEY_W'(1) : seed;
    end else begin
      lfsr <= next_lfsr;
    end
  end

  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (reset) lfsr != '0);

endmodule

// File: rtl/lfsr_key_source.sv
// LFSR key source: warm-up after reset/reseed, then keys over valid/ready.
module lfsr_key_source
  import lfsr_key_pkg::*;
#(
  parameter int               KEY_W    = 128,
  parameter int               STEP     = 8,
  parameter logic [KEY_W-1:0] TAP_MASK = KEY_W'(TAP_MASK_128),
  parameter logic [KEY_W-1:0] SEED_DEF = KEY_W'(1),
  parameter int               WARMUP   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [KEY_W-1:0] seed_data,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] key_data,
  output logic [31:0]      key_count,
  output logic             warming
);

  localparam int               CNT_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] lfsr;
  logic             seed_acc;

  assign seed_acc = seed_valid && seed_ready;
  assign warming  = (state == WARM);

  lfsr_core #(
    .KEY_W    (KEY_W),
    .STEP     (STEP),
    .TAP_MASK (TAP_MASK),
    .SEED_DEF (SEED_DEF)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (seed_acc),
    .seed  (seed_data),
    .lfsr  (lfsr)
  );

  // FSM, warm-up counter, key output register, handshake counter and seed_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WARM;
      cnt        <= CNT_INIT;
      key_valid  <= 1'b0;
      key_data   <= '0;
      key_count  <= '0;
      seed_ready <= 1'b0;
    end else begin
      seed_ready <= 1'b1;
      // A handshake on the reseed edge still counts; the reseed then drops key_valid.
      if (key_valid && key_ready) begin
        key_count <= key_count + 32'd1;
      end
      if (seed_acc) begin
        state     <= WARM;
        cnt       <= CNT_INIT;
        key_valid <= 1'b0;
      end else begin
        case (state)
          WARM: begin
            key_valid <= 1'b0;
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            if (!key_valid || key_ready) begin
              key_data  <= lfsr;
              key_valid <= 1'b1;
            end
          end
          default: state <= WARM;
        endcase
      end
    end
  end

  a_key_stable: assert property (@(posedge clk) disable iff (reset)
    key_valid && !key_ready |=> $stable(key_data));
  a_no_valid_in_warm: assert property (@(posedge clk) disable iff (reset)
    !(state == WARM && key_valid));

endmodule

// File: tb/tb_lfsr_key_source.sv
// Bench for lfsr_key_source (KEY_W=128, STEP=1, WARMUP=4): timeline reference model,
// directed scenarios with literal expectations, random stream, mid-stream async reset.
module tb_lfsr_key_source;

  localparam int KW = 128;
  localparam int ST = 1;
  localparam int WU = 4;
  localparam logic [127:0] TAPS = (128'd1 << 127) | (128'd1 << 126) |
                                  (128'd1 << 125) | (128'd1 << 120);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          seed_valid = 1'b0;
  logic          seed_ready;
  logic [KW-1:0] seed_data = '0;
  logic          key_valid;
  logic          key_ready = 1'b0;
  logic [KW-1:0] key_data;
  logic [31:0]   key_count;
  logic          warming;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: LFSR value, edges since last (re)seed, delivered key state.
  logic [127:0] m_lfsr;
  int           m_since;
  logic         m_valid;
  logic [127:0] m_key;
  logic [31:0]  m_count;
  logic         m_sready;

  always #5 clk = ~clk;

  lfsr_key_source #(
    .KEY_W    (KW),
    .STEP     (ST),
    .TAP_MASK (TAPS),
    .SEED_DEF (128'd1),
    .WARMUP   (WU)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_data  (seed_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_data   (key_data),
    .key_count  (key_count),
    .warming    (warming)
  );

  function automatic logic [127:0] step1(input logic [127:0] v);
    return {v[126:0], ^(v & TAPS)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr   = 128'd1;
    m_since  = 0;
    m_valid  = 1'b0;
    m_key    = '0;
    m_count  = '0;
    m_sready = 1'b0;
  endtask

  // One clock edge of the reference: keys appear once WARMUP edges have passed since
  // the last (re)seed, and a new key is taken whenever the slot is empty or accepted.
  task automatic model_edge(input logic sv, input logic [127:0] sd, input logic kr);
    logic acc;
    acc = sv && m_sready;
    if (m_valid && kr) m_count = m_count + 32'd1;
    m_sready = 1'b1;
    if (acc) begin
      m_lfsr  = (sd == '0) ? 128'd1 : sd;
      m_since = 0;
      m_valid = 1'b0;
    end else begin
      if (m_since >= WU && (!m_valid || kr)) begin
        m_key   = m_lfsr;
        m_valid = 1'b1;
      end
      if (m_since <= WU) m_since++;
      for (int i = 0; i < ST; i++) m_lfsr = step1(m_lfsr);
    end
  endtask

  task automatic compare_all();
    check("key_valid", 128'(key_valid), 128'(m_valid));
    check("key_data", key_data, m_key);
    check("key_count", 128'(key_count), 128'(m_count));
    check("seed_ready", 128'(seed_ready), 128'(m_sready));
    check("warming", 128'(warming), 128'(m_since < WU));
  endtask

  // Drive at the falling edge, let one rising edge happen, then compare at the next falling edge.
  task automatic tick(input logic sv, input logic [127:0] sd, input logic kr);
    seed_valid = sv;
    seed_data  = sd;
    key_ready  = kr;
    @(posedge clk);
    model_edge(sv, sd, kr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    seed_valid = 1'b0;
    key_ready  = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;
  endtask

  task automatic scenario_basic();
    for (int e = 1; e <= 4; e++) tick(1'b0, '0, 1'b1);
    check("lit_valid_before_e5", 128'(key_valid), 128'd0);
    tick(1'b0, '0, 1'b1);
    check("lit_valid_e5", 128'(key_valid), 128'd1);
    check("lit_key_e5", key_data, 128'h10);
    tick(1'b0, '0, 1'b1);
    check("lit_key_e6", key_data, 128'h20);
    tick(1'b0, '0, 1'b1);
    check("lit_key_e7", key_data, 128'h40);
    tick(1'b0, '0, 1'b1);
    check("lit_count_3", 128'(key_count), 128'd3);
  endtask

  initial begin
    logic [127:0] rs;

    @(negedge clk);
    do_reset();
    check("lit_rst_seed_ready", 128'(seed_ready), 128'd0);
    check("lit_rst_warming", 128'(warming), 128'd1);

    // Scenario 1: free-running keys.
    scenario_basic();

    // Scenario 2: stall from edge 5 to edge 8, accept on edge 9.
    do_reset();
    for (int e = 1; e <= 4; e++) tick(1'b0, '0, 1'b1);
    for (int e = 5; e <= 8; e++) begin
      tick(1'b0, '0, 1'b0);
      check("lit_stall_key", key_data, 128'h10);
    end
    tick(1'b0, '0, 1'b1);
    check("lit_e9_key", key_data, 128'h100);
    check("lit_e9_count", 128'(key_count), 128'd1);

    // Scenario 3: feedback wrap; seed on edge 2 so the first key is 1<<120.
    do_reset();
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 128'd1 << 116, 1'b1);
    for (int e = 1; e <= 4; e++) tick(1'b0, '0, 1'b1);
    check("lit_wrap_not_yet", 128'(key_valid), 128'd0);
    tick(1'b0, '0, 1'b1);
    check("lit_wrap_k0", key_data, 128'd1 << 120);
    tick(1'b0, '0, 1'b1);
    check("lit_wrap_k1", key_data, (128'd1 << 121) | 128'd1);
    check("lit_wrap_count", 128'(key_count), 128'd1);

    // Scenario 4: zero seed over a pending key.
    tick(1'b0, '0, 1'b0);
    tick(1'b1, '0, 1'b0);
    check("lit_zseed_valid", 128'(key_valid), 128'd0);
    check("lit_zseed_count", 128'(key_count), 128'd1);
    for (int e = 1; e <= 4; e++) tick(1'b0, '0, 1'b0);
    check("lit_zseed_wait", 128'(key_valid), 128'd0);
    tick(1'b0, '0, 1'b0);
    check("lit_zseed_key", key_data, 128'h10);
    check("lit_zseed_valid2", 128'(key_valid), 128'd1);

    // Scenario 5: seed and handshake on the same edge.
    rs = {$urandom, $urandom, $urandom, $urandom};
    tick(1'b1, rs, 1'b1);
    check("lit_same_count", 128'(key_count), 128'd2);
    check("lit_same_valid", 128'(key_valid), 128'd0);
    check("lit_same_warm0", 128'(warming), 128'd1);
    for (int e = 1; e <= 3; e++) begin
      tick(1'b0, '0, 1'b1);
      check("lit_same_warm", 128'(warming), 128'd1);
    end
    tick(1'b0, '0, 1'b1);
    check("lit_same_run", 128'(warming), 128'd0);

    // Random stream against the model.
    for (int n = 0; n < 1500; n++) begin
      rs = ($urandom_range(0, 3) == 0) ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
      tick($urandom_range(0, 15) == 0, rs, $urandom_range(0, 2) != 0);
    end

    // Scenario 6: asynchronous reset mid-stream, then the first scenario again.
    #2;
    reset = 1'b1;
    #1;
    check("lit_async_valid", 128'(key_valid), 128'd0);
    check("lit_async_count", 128'(key_count), 128'd0);
    check("lit_async_sready", 128'(seed_ready), 128'd0);
    check("lit_async_warming", 128'(warming), 128'd1);
    check("lit_async_key", key_data, 128'd0);
    @(negedge clk);
    do_reset();
    scenario_basic();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
